// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised pipeline-stage registers.
// The state encoding doubles as the occupancy count reported by each stage.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    // Field widths shared by every pipeline stage unless overridden
    localparam int PIPE_CTRL_W = 2;
    localparam int PIPE_DATA_W = 64;
    localparam int PIPE_RD_W   = 5;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_FULL  = ST_FULL,
        S_SKID  = ST_SKID
    } skid_state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage entry of a pipeline stage: a {ctrl,data,rd} payload register with
// a load enable plus a valid bit. The payload is only ever zeroed by reset so a
// drained entry keeps presenting its last data; the valid bit alone says whether
// the entry holds a live instruction.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int RD_W   = PIPE_RD_W
) (
    input  logic              Clock_i,
    input  logic              Reset_i,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] next_ctrl,
    input  logic [DATA_W-1:0] next_data,
    input  logic [RD_W-1:0]   next_rd,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data,
    output logic [RD_W-1:0]   rd
);

    // Payload capture: load on demand, otherwise hold the last value
    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            ctrl <= '0;
            data <= '0;
            rd   <= '0;
        end else if (load) begin
            ctrl <= next_ctrl;
            data <= next_data;
            rd   <= next_rd;
        end
    end

    // Valid bit: set by a load, dropped by a synchronous clear (load wins)
    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic pipeline-stage register with valid/ready handshake, optional 2-entry
// skid buffer, synchronous flush and bubbling of the control/rd fields.
// With SKID_EN=1 the upstream ready depends only on local state, stall and
// flush, never on out_ready_i, which breaks the ready path between stages.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W  = PIPE_CTRL_W,
    parameter int DATA_W  = PIPE_DATA_W,
    parameter int RD_W    = PIPE_RD_W,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              Clock_i,
    input  logic              Reset_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [RD_W-1:0]   in_rd_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [RD_W-1:0]   out_rd_o,
    output logic [1:0]        occupancy_o
);

    skid_state_t state, state_n;
    logic [1:0]  state_bits;
    logic        state_bad;

    logic        accept, fire;
    logic        main_load, main_clear, main_from_skid;
    logic        skid_load, skid_clear;

    logic              main_v, skid_v;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_next_ctrl;
    logic [DATA_W-1:0] main_data, skid_data, main_next_data;
    logic [RD_W-1:0]   main_rd, skid_rd, main_next_rd;

    assign state_bits  = state;
    assign state_bad   = (state_bits == 2'b11);
    assign occupancy_o = state_bits;

    // Handshake: in skid mode ready is purely local; in single mode it looks through to downstream
    always_comb begin
        if (SKID_EN) begin
            in_ready_o = (state != S_SKID) && !stall_i && !flush_i;
        end else begin
            in_ready_o = (!main_v || out_ready_i) && !stall_i && !flush_i;
        end
    end

    assign out_valid_o = main_v && !stall_i;
    assign accept      = in_valid_i && in_ready_o;
    assign fire        = out_valid_o && out_ready_i;

    // Bubbles present ctrl/rd as zero so downstream sees an explicit NOP; data just holds
    assign out_ctrl_o = out_valid_o ? main_ctrl : '0;
    assign out_rd_o   = out_valid_o ? main_rd   : '0;
    assign out_data_o = main_data;

    // The main entry refills either from the input or from the skid entry when draining
    assign main_next_ctrl = main_from_skid ? skid_ctrl : in_ctrl_i;
    assign main_next_data = main_from_skid ? skid_data : in_data_i;
    assign main_next_rd   = main_from_skid ? skid_rd   : in_rd_i;

    // State register
    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state <= S_EMPTY;
        end else begin
            state <= state_n;
        end
    end

    // Next state and entry control: flush (or an illegal state) empties everything, stall holds
    always_comb begin
        state_n        = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush_i || state_bad) begin
            state_n    = S_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (!stall_i) begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_n   = S_FULL;
                    end
                end
                S_FULL: begin
                    if (accept && fire) begin
                        main_load = 1'b1;
                    end else if (accept && SKID_EN) begin
                        skid_load = 1'b1;
                        state_n   = S_SKID;
                    end else if (fire) begin
                        main_clear = 1'b1;
                        state_n    = S_EMPTY;
                    end
                end
                S_SKID: begin
                    if (fire) begin
                        if (skid_v) begin
                            main_load      = 1'b1;
                            main_from_skid = 1'b1;
                            skid_clear     = 1'b1;
                            state_n        = S_FULL;
                        end else begin
                            main_clear = 1'b1;
                            state_n    = S_EMPTY;
                        end
                    end
                end
                default: begin
                    state_n = S_EMPTY;
                end
            endcase
        end
    end

    pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_main (
        .Clock_i   (Clock_i),
        .Reset_i   (Reset_i),
        .load      (main_load),
        .clear     (main_clear),
        .next_ctrl (main_next_ctrl),
        .next_data (main_next_data),
        .next_rd   (main_next_rd),
        .valid     (main_v),
        .ctrl      (main_ctrl),
        .data      (main_data),
        .rd        (main_rd)
    );

    pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_skid (
        .Clock_i   (Clock_i),
        .Reset_i   (Reset_i),
        .load      (skid_load),
        .clear     (skid_clear),
        .next_ctrl (in_ctrl_i),
        .next_data (in_data_i),
        .next_rd   (in_rd_i),
        .valid     (skid_v),
        .ctrl      (skid_ctrl),
        .data      (skid_data),
        .rd        (skid_rd)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: drives a skid-buffered instance and a single-entry
// instance from the same inputs and compares both against a queue model of a
// FIFO stage with capacity 2 or 1.
module tb_pipe_skid_stage;

    localparam int CW = 2;
    localparam int DW = 64;
    localparam int RW = 5;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        logic [RW-1:0] rd;
    } ent_t;

    logic          Clock_i = 1'b0;
    logic          Reset_i, stall_i, flush_i, in_valid_i, out_ready_i;
    logic [CW-1:0] in_ctrl_i;
    logic [DW-1:0] in_data_i;
    logic [RW-1:0] in_rd_i;

    logic          in_ready_w  [2];
    logic          out_valid_w [2];
    logic [CW-1:0] out_ctrl_w  [2];
    logic [DW-1:0] out_data_w  [2];
    logic [RW-1:0] out_rd_w    [2];
    logic [1:0]    occupancy_w [2];

    ent_t          mq0[$];
    ent_t          mq1[$];
    logic [DW-1:0] held0, held1;
    bit            model_known = 1'b0;
    int            single_occ_max = 0;
    int            checks = 0;
    int            failures = 0;

    always #5 Clock_i = ~Clock_i;

    pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .RD_W(RW), .SKID_EN(1'b1)) u_dut_skid (
        .Clock_i(Clock_i), .Reset_i(Reset_i), .stall_i(stall_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_w[0]), .in_ctrl_i(in_ctrl_i),
        .in_data_i(in_data_i), .in_rd_i(in_rd_i), .out_valid_o(out_valid_w[0]),
        .out_ready_i(out_ready_i), .out_ctrl_o(out_ctrl_w[0]), .out_data_o(out_data_w[0]),
        .out_rd_o(out_rd_w[0]), .occupancy_o(occupancy_w[0])
    );

    pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .RD_W(RW), .SKID_EN(1'b0)) u_dut_single (
        .Clock_i(Clock_i), .Reset_i(Reset_i), .stall_i(stall_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_w[1]), .in_ctrl_i(in_ctrl_i),
        .in_data_i(in_data_i), .in_rd_i(in_rd_i), .out_valid_o(out_valid_w[1]),
        .out_ready_i(out_ready_i), .out_ctrl_o(out_ctrl_w[1]), .out_data_o(out_data_w[1]),
        .out_rd_o(out_rd_w[1]), .occupancy_o(occupancy_w[1])
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare one instance with its model, then advance the model across the coming edge
    task automatic stepInst(input int i);
        ent_t          q[$];
        ent_t          e;
        logic [DW-1:0] held;
        int            cap;
        string         nm;
        logic          exp_ready, exp_valid, do_fire, do_accept;
        logic [CW-1:0] exp_ctrl;
        logic [DW-1:0] exp_data;
        logic [RW-1:0] exp_rd;
        if (i == 0) begin
            q = mq0; held = held0; cap = 2; nm = "skid";
        end else begin
            q = mq1; held = held1; cap = 1; nm = "single";
        end
        if (cap == 2) exp_ready = !stall_i && !flush_i && (q.size() < 2);
        else          exp_ready = !stall_i && !flush_i && (q.size() == 0 || out_ready_i);
        exp_valid = (q.size() > 0) && !stall_i;
        exp_ctrl  = '0;
        exp_rd    = '0;
        exp_data  = held;
        if (q.size() > 0) begin
            exp_data = q[0].data;
            if (exp_valid) begin
                exp_ctrl = q[0].ctrl;
                exp_rd   = q[0].rd;
            end
        end
        if (model_known) begin
            checkOutput({nm, "_in_ready"},  64'(in_ready_w[i]),  64'(exp_ready));
            checkOutput({nm, "_out_valid"}, 64'(out_valid_w[i]), 64'(exp_valid));
            checkOutput({nm, "_out_ctrl"},  64'(out_ctrl_w[i]),  64'(exp_ctrl));
            checkOutput({nm, "_out_data"},  out_data_w[i],       exp_data);
            checkOutput({nm, "_out_rd"},    64'(out_rd_w[i]),    64'(exp_rd));
            checkOutput({nm, "_occupancy"}, 64'(occupancy_w[i]), 64'(q.size()));
            if (i == 1 && int'(occupancy_w[1]) > single_occ_max) single_occ_max = int'(occupancy_w[1]);
        end
        if (Reset_i) begin
            q.delete();
            held = '0;
        end else if (flush_i) begin
            q.delete();
        end else if (!stall_i) begin
            do_fire   = (q.size() > 0) && out_ready_i;
            do_accept = in_valid_i && exp_ready;
            if (do_fire) void'(q.pop_front());
            if (do_accept) begin
                e.ctrl = in_ctrl_i;
                e.data = in_data_i;
                e.rd   = in_rd_i;
                q.push_back(e);
            end
        end
        if (q.size() > 0) held = q[0].data;
        if (i == 0) begin
            mq0 = q; held0 = held;
        end else begin
            mq1 = q; held1 = held;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check, then cross the rising edge
    task automatic applyStimulus(input logic rst, input logic stl, input logic fl, input logic vld,
                                 input logic rdy, input logic [CW-1:0] c, input logic [DW-1:0] d,
                                 input logic [RW-1:0] r);
        Reset_i = rst; stall_i = stl; flush_i = fl; in_valid_i = vld; out_ready_i = rdy;
        in_ctrl_i = c; in_data_i = d; in_rd_i = r;
        #1;
        stepInst(0);
        stepInst(1);
        if (rst) model_known = 1'b1;
        @(posedge Clock_i);
        @(negedge Clock_i);
    endtask

    initial begin
        Reset_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        in_ctrl_i = '0; in_data_i = '0; in_rd_i = '0;
        @(negedge Clock_i);

        // Reset held two cycles with upstream valid, then release
        applyStimulus(1, 0, 0, 1, 0, 2'd1, 64'd99, 5'd3);
        applyStimulus(1, 0, 0, 1, 0, 2'd1, 64'd99, 5'd3);
        checkOutput("t1_occ_after_reset", 64'(occupancy_w[0]), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 2'd0, 64'd0, 5'd0);

        // Back-to-back stream 1..8 with downstream always ready
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 0, 0, 1, 1, CW'(k), DW'(k), RW'(k));
            checkOutput("t2_occ_stream", 64'(occupancy_w[0]), 64'd1);
        end
        applyStimulus(0, 0, 0, 0, 1, 2'd0, 64'd0, 5'd0);

        // Overflow into the skid entry, then drain in order
        applyStimulus(0, 0, 0, 1, 0, 2'd1, 64'd5, 5'd5);
        applyStimulus(0, 0, 0, 1, 0, 2'd2, 64'd6, 5'd6);
        checkOutput("t3_skid_occ", 64'(occupancy_w[0]), 64'd2);
        checkOutput("t3_skid_ready", 64'(in_ready_w[0]), 64'd0);
        checkOutput("t6_single_holdoff", 64'(in_ready_w[1]), 64'd0);
        applyStimulus(0, 0, 0, 1, 1, 2'd2, 64'd6, 5'd6);
        applyStimulus(0, 0, 0, 0, 1, 2'd0, 64'd0, 5'd0);
        applyStimulus(0, 0, 0, 0, 1, 2'd0, 64'd0, 5'd0);

        // Flush while both entries are held, with a new input offered
        applyStimulus(0, 0, 0, 1, 0, 2'd1, 64'd5, 5'd5);
        applyStimulus(0, 0, 0, 1, 0, 2'd2, 64'd6, 5'd6);
        applyStimulus(0, 0, 1, 1, 0, 2'd3, 64'd7, 5'd7);
        checkOutput("t4_flush_occ", 64'(occupancy_w[0]), 64'd0);
        checkOutput("t4_flush_valid", 64'(out_valid_w[0]), 64'd0);
        applyStimulus(0, 0, 0, 0, 1, 2'd0, 64'd0, 5'd0);
        applyStimulus(0, 0, 0, 0, 1, 2'd0, 64'd0, 5'd0);

        // Stall a full stage for three cycles, then let it fire once
        applyStimulus(0, 0, 0, 1, 0, 2'd3, 64'd9, 5'd9);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0, 1, 2'd0, 64'd0, 5'd0);
        checkOutput("t5_stall_occ", 64'(occupancy_w[0]), 64'd1);
        applyStimulus(0, 0, 0, 0, 1, 2'd0, 64'd0, 5'd0);
        applyStimulus(0, 0, 0, 0, 1, 2'd0, 64'd0, 5'd0);
        applyStimulus(0, 1, 1, 1, 1, 2'd1, 64'd11, 5'd11);

        // Randomised traffic with occasional stall, flush and reset
        for (int k = 0; k < 600; k++) begin
            applyStimulus(($urandom_range(63) == 0), ($urandom_range(7) == 0), ($urandom_range(15) == 0),
                          ($urandom_range(3) != 0), ($urandom_range(2) != 0),
                          CW'($urandom_range(3)), {$urandom, $urandom}, RW'($urandom_range(31)));
        end

        checkOutput("t6_single_occ_max", 64'(single_occ_max), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
